// File: rtl/new_cache_pkg.sv
// Shared types and select encodings for the cache control FSM and its datapath.
package new_cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;

  // Per-way data array write-enable select
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_ALL  = 2'b01;
  localparam logic [1:0] WE_MASK = 2'b10;

  // Data array input source
  localparam logic DIN_PMEM = 1'b0;
  localparam logic DIN_CPU  = 1'b1;

  // Physical memory address source
  localparam logic PADDR_WB  = 1'b0;
  localparam logic PADDR_CPU = 1'b1;

endpackage

// File: rtl/new_cache_control_sat_counter.sv
// Saturating up-counter used for the cache performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/new_cache_control.sv
// Control FSM for the 2-way set-associative write-back, write-allocate cache.
// Sequences compare, writeback and line fill, and drives all datapath strobes.
module new_cache_control
  import new_cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // CPU side
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  // Cacheline adapter side
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  // Datapath status
  input  logic             miss,
  input  logic             way,
  input  logic             dirty_out,
  // Datapath controls
  output logic             data_in_sel,
  output logic             pmem_addr_sel,
  output logic [1:0]       wr_en_data_0_sel,
  output logic [1:0]       wr_en_data_1_sel,
  output logic             dirty_in,
  output logic             valid_in,
  output logic             ld_dirty_0,
  output logic             ld_dirty_1,
  output logic             ld_valid_0,
  output logic             ld_valid_1,
  output logic             ld_tag_0,
  output logic             ld_tag_1,
  output logic             ld_lru,
  // Performance counters
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  state_t state;
  logic   miss_seen;     // request already counted as a miss
  logic   req;
  logic   hit_inc;
  logic   miss_inc;
  logic   wb_inc;

  // Way-indexed strobes, fanned out to the per-way ports below
  logic [1:0] wr_en_sel [2];
  logic [1:0] ld_dirty_v;
  logic [1:0] ld_valid_v;
  logic [1:0] ld_tag_v;

  assign req = mem_read | mem_write;

  // State transitions and the miss-already-counted flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      miss_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) state <= COMPARE;
        end
        COMPARE: begin
          if (!req) begin
            // Request dropped during a miss: abandon quietly
            state     <= IDLE;
            miss_seen <= 1'b0;
          end else if (!miss) begin
            state     <= IDLE;
            miss_seen <= 1'b0;
          end else begin
            miss_seen <= 1'b1;
            state     <= dirty_out ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (pmem_resp) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational datapath controls from state and inputs
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    data_in_sel   = DIN_PMEM;
    pmem_addr_sel = PADDR_CPU;
    dirty_in      = 1'b0;
    valid_in      = 1'b0;
    ld_lru        = 1'b0;
    wr_en_sel[0]  = WE_NONE;
    wr_en_sel[1]  = WE_NONE;
    ld_dirty_v    = 2'b00;
    ld_valid_v    = 2'b00;
    ld_tag_v      = 2'b00;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    case (state)
      COMPARE: begin
        if (req && !miss) begin
          mem_resp = 1'b1;
          ld_lru   = 1'b1;
          hit_inc  = !miss_seen;
          // Write wins when both read and write are asserted
          if (mem_write) begin
            wr_en_sel[way]  = WE_MASK;
            data_in_sel     = DIN_CPU;
            ld_dirty_v[way] = 1'b1;
            dirty_in        = 1'b1;
          end
        end else if (req && miss) begin
          miss_inc = !miss_seen;
        end
      end
      WRITEBACK: begin
        pmem_addr_sel = PADDR_WB;
        pmem_write    = 1'b1;
        wb_inc        = pmem_resp;
      end
      ALLOCATE: begin
        pmem_addr_sel = PADDR_CPU;
        pmem_read     = 1'b1;
        if (pmem_resp) begin
          wr_en_sel[way]  = WE_ALL;
          data_in_sel     = DIN_PMEM;
          ld_tag_v[way]   = 1'b1;
          ld_valid_v[way] = 1'b1;
          valid_in        = 1'b1;
          ld_dirty_v[way] = 1'b1;
          dirty_in        = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign wr_en_data_0_sel = wr_en_sel[0];
  assign wr_en_data_1_sel = wr_en_sel[1];
  assign ld_dirty_0       = ld_dirty_v[0];
  assign ld_dirty_1       = ld_dirty_v[1];
  assign ld_valid_0       = ld_valid_v[0];
  assign ld_valid_1       = ld_valid_v[1];
  assign ld_tag_0         = ld_tag_v[0];
  assign ld_tag_1         = ld_tag_v[1];

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_new_cache_control.sv
// Directed bench for new_cache_control, built with 4-bit counters.
module tb_new_cache_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read, mem_write, mem_resp;
  logic             pmem_read, pmem_write, pmem_resp;
  logic             miss, way, dirty_out;
  logic             data_in_sel, pmem_addr_sel;
  logic [1:0]       wr_en_data_0_sel, wr_en_data_1_sel;
  logic             dirty_in, valid_in;
  logic             ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1;
  logic             ld_tag_0, ld_tag_1, ld_lru;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  int total = 0;
  int bad   = 0;

  new_cache_control #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_resp         (mem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_resp        (pmem_resp),
    .miss             (miss),
    .way              (way),
    .dirty_out        (dirty_out),
    .data_in_sel      (data_in_sel),
    .pmem_addr_sel    (pmem_addr_sel),
    .wr_en_data_0_sel (wr_en_data_0_sel),
    .wr_en_data_1_sel (wr_en_data_1_sel),
    .dirty_in         (dirty_in),
    .valid_in         (valid_in),
    .ld_dirty_0       (ld_dirty_0),
    .ld_dirty_1       (ld_dirty_1),
    .ld_valid_0       (ld_valid_0),
    .ld_valid_1       (ld_valid_1),
    .ld_tag_0         (ld_tag_0),
    .ld_tag_1         (ld_tag_1),
    .ld_lru           (ld_lru),
    .hit_count        (hit_count),
    .miss_count       (miss_count),
    .wb_count         (wb_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read hit in way 0, starting and ending in IDLE
  task automatic read_hit();
    mem_read = 1'b1; mem_write = 1'b0; miss = 1'b0; way = 1'b0;
    tick();
    tick();
    mem_read = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    miss = 0; way = 0; dirty_out = 0;
    #1;
    check_val("rst_hit_count", hit_count, 0);
    check_val("rst_miss_count", miss_count, 0);
    check_val("rst_wb_count", wb_count, 0);
    check_val("rst_mem_resp", mem_resp, 0);
    check_val("rst_addr_sel", pmem_addr_sel, 1);
    tick();
    rst = 1'b1;
    tick();

    // Read hit, way 0
    mem_read = 1; miss = 0; way = 0;
    #1;
    check_val("rh_idle_resp", mem_resp, 0);
    check_val("rh_idle_lru", ld_lru, 0);
    tick();
    check_val("rh_resp", mem_resp, 1);
    check_val("rh_lru", ld_lru, 1);
    check_val("rh_pmem", {pmem_read, pmem_write}, 0);
    check_val("rh_we0", wr_en_data_0_sel, 0);
    tick();
    mem_read = 0;
    #1;
    check_val("rh_resp_gone", mem_resp, 0);
    check_val("rh_hit_count", hit_count, 1);

    // Write hit, way 1
    mem_write = 1; way = 1;
    tick();
    check_val("wh_we1", wr_en_data_1_sel, 2);
    check_val("wh_we0", wr_en_data_0_sel, 0);
    check_val("wh_din_sel", data_in_sel, 1);
    check_val("wh_ld_dirty", {ld_dirty_1, ld_dirty_0}, 2'b10);
    check_val("wh_dirty_in", dirty_in, 1);
    check_val("wh_resp", mem_resp, 1);
    tick();
    mem_write = 0;
    #1;
    check_val("wh_hit_count", hit_count, 2);

    // Clean miss, way 1, fill answered on the 5th cycle
    mem_read = 1; miss = 1; dirty_out = 0; way = 1;
    tick();
    check_val("cm_cmp_resp", mem_resp, 0);
    check_val("cm_cmp_loads", {ld_lru, ld_tag_1, ld_valid_1, ld_dirty_1}, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("cm_pread", {pmem_read, pmem_write, pmem_addr_sel}, 3'b101);
      check_val("cm_noload", ld_tag_1, 0);
      tick();
    end
    pmem_resp = 1;
    #1;
    check_val("cm_pread_last", pmem_read, 1);
    check_val("cm_we1", wr_en_data_1_sel, 1);
    check_val("cm_we0", wr_en_data_0_sel, 0);
    check_val("cm_loads1", {ld_tag_1, ld_valid_1, valid_in, ld_dirty_1, dirty_in, data_in_sel}, 6'b111100);
    check_val("cm_loads0", {ld_tag_0, ld_valid_0, ld_dirty_0}, 0);
    tick();
    pmem_resp = 0; miss = 0;
    #1;
    check_val("cm_fill_wait", {mem_resp, pmem_read, pmem_write, ld_lru}, 0);
    tick();
    check_val("cm_recmp_resp", mem_resp, 1);
    tick();
    mem_read = 0;
    #1;
    check_val("cm_miss_count", miss_count, 1);
    check_val("cm_hit_count", hit_count, 2);

    // Dirty write miss, way 0: writeback 3 cycles, fill 2 cycles
    mem_write = 1; miss = 1; dirty_out = 1; way = 0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pmem_resp = 1;
      #1;
      check_val("dm_pwrite", {pmem_write, pmem_read, pmem_addr_sel}, 3'b100);
      tick();
    end
    pmem_resp = 0;
    #1;
    check_val("dm_wb_count", wb_count, 1);
    check_val("dm_pread", {pmem_read, pmem_write, pmem_addr_sel}, 3'b101);
    tick();
    pmem_resp = 1;
    #1;
    check_val("dm_fill_we", {wr_en_data_1_sel, wr_en_data_0_sel}, 4'b0001);
    tick();
    pmem_resp = 0; miss = 0; dirty_out = 0;
    tick();
    check_val("dm_merge_we0", wr_en_data_0_sel, 2);
    check_val("dm_merge_dirty", {ld_dirty_0, dirty_in, data_in_sel}, 3'b111);
    check_val("dm_resp", mem_resp, 1);
    tick();
    mem_write = 0;
    #1;
    check_val("dm_counts", {hit_count, miss_count, wb_count}, {4'd2, 4'd2, 4'd1});

    // Read and write together count as a write
    mem_read = 1; mem_write = 1; miss = 0; way = 0;
    tick();
    check_val("rw_we0", wr_en_data_0_sel, 2);
    tick();
    mem_read = 0; mem_write = 0;

    // pmem_resp in IDLE is ignored
    pmem_resp = 1;
    tick();
    check_val("idle_presp", {pmem_read, pmem_write, mem_resp}, 0);
    pmem_resp = 0;

    // Reset asserted while in ALLOCATE
    mem_read = 1; miss = 1; dirty_out = 0; way = 0;
    tick();
    tick();
    check_val("ra_pread", pmem_read, 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("ra_pread_drop", pmem_read, 0);
    check_val("ra_counts", {hit_count, miss_count, wb_count}, 0);
    check_val("ra_loads", {ld_tag_0, ld_valid_0, ld_dirty_0, ld_lru}, 0);
    mem_read = 0; miss = 0;
    tick();
    rst = 1'b1;
    tick();

    // Saturation of the 4-bit hit counter
    for (int i = 0; i < 15; i++) read_hit();
    #1;
    check_val("sat_15", hit_count, 15);
    for (int i = 0; i < 4; i++) read_hit();
    #1;
    check_val("sat_19", hit_count, 15);
    check_val("sat_miss", miss_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
